// File: rtl/rv32i_types.sv
// Shared fetch-side types for the rv32i pipeline.
// Fetch queue entries and the metadata tracked per outstanding request.
package rv32i_types;

    localparam int FQ_ORDER_W = 64;

    typedef struct packed {
        logic [31:0]           inst;
        logic [31:0]           pc;
        logic [31:0]           pc_next;
        logic [FQ_ORDER_W-1:0] order;
    } fetch_queue_t;

    typedef struct packed {
        logic [31:0]           pc;
        logic [31:0]           pc_next;
        logic [FQ_ORDER_W-1:0] order;
    } fetch_meta_t;

endpackage

// File: rtl/fetch_fifo.sv
// Register-based synchronous FIFO with flush and occupancy count.
// Power-of-two depth; writes to a full FIFO and reads from an empty one are ignored.
module fetch_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = count == CW'(DEPTH);
    assign empty   = count == '0;
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!rst || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/fetch_pipelined.sv
// Pipelined instruction fetch: multiple outstanding requests, in-order
// responses, redirect with stale-response dropping.
module fetch_pipelined
    import rv32i_types::*;
#(
    parameter logic [31:0] RESET_PC        = 32'h6000_0000,
    parameter int          MAX_OUTSTANDING = 4,
    parameter int          ORDER_W         = 64
) (
    input  logic               clk,
    input  logic               rst,
    output logic [31:0]        imem_addr,
    output logic [3:0]         imem_rmask,
    input  logic               imem_ready,
    input  logic [31:0]        imem_rdata,
    input  logic               imem_resp,
    input  logic               full_fq,
    output logic               fetch_valid,
    output fetch_queue_t       fetch_data,
    input  logic               br_flush,
    input  logic [31:0]        br_addr,
    input  logic [ORDER_W-1:0] br_order,
    input  logic               jal_ready,
    input  logic [31:0]        jal_addr,
    input  logic [ORDER_W-1:0] jal_order
);

    localparam int CW = $clog2(MAX_OUTSTANDING) + 1;
    localparam int MW = $bits(fetch_meta_t);
    localparam int QW = $bits(fetch_queue_t);

    logic [31:0]        pc;
    logic [ORDER_W-1:0] order;
    logic [CW-1:0]      inflight;
    logic [CW-1:0]      drop_cnt;
    logic [CW-1:0]      meta_cnt;
    logic [CW-1:0]      resp_cnt;
    logic [CW:0]        pending;
    logic               redirect;
    logic [31:0]        tgt_pc;
    logic [ORDER_W-1:0] tgt_order;
    logic               issue;
    logic               accept;
    logic               resp_any;
    logic               resp_live;
    logic               meta_full;
    logic               meta_empty;
    logic               resp_full;
    logic               resp_empty;
    fetch_meta_t        meta_in;
    fetch_meta_t        meta_head;
    fetch_queue_t       resp_in;
    fetch_queue_t       resp_head;

    assign redirect  = br_flush | jal_ready;
    assign tgt_pc    = br_flush ? br_addr : jal_addr;
    assign tgt_order = br_flush ? br_order : jal_order;

    assign pending = {1'b0, inflight} + {1'b0, resp_cnt};
    assign issue   = rst & ~redirect & ~meta_full & ~resp_full
                   & (pending < (CW+1)'(MAX_OUTSTANDING));
    assign accept  = issue & imem_ready;

    // Responses only count against requests we actually have outstanding.
    assign resp_any  = imem_resp & (inflight != '0);
    assign resp_live = resp_any & (drop_cnt == '0) & ~meta_empty;

    assign imem_addr   = pc;
    assign imem_rmask  = issue ? 4'b1111 : 4'b0000;
    assign fetch_valid = rst & ~redirect & ~resp_empty;
    assign fetch_data  = resp_head;

    assign meta_in = '{
        pc:      pc,
        pc_next: pc + 32'd4,
        order:   FQ_ORDER_W'(order)
    };

    assign resp_in = '{
        inst:    imem_rdata,
        pc:      meta_head.pc,
        pc_next: meta_head.pc_next,
        order:   meta_head.order
    };

    fetch_fifo #(.WIDTH(MW), .DEPTH(MAX_OUTSTANDING)) meta_q (
        .clk   (clk),
        .rst   (rst),
        .push  (accept),
        .pop   (resp_live),
        .flush (redirect),
        .din   (meta_in),
        .dout  (meta_head),
        .full  (meta_full),
        .empty (meta_empty),
        .count (meta_cnt)
    );

    fetch_fifo #(.WIDTH(QW), .DEPTH(MAX_OUTSTANDING)) resp_q (
        .clk   (clk),
        .rst   (rst),
        .push  (resp_live & ~redirect),
        .pop   (fetch_valid & ~full_fq),
        .flush (redirect),
        .din   (resp_in),
        .dout  (resp_head),
        .full  (resp_full),
        .empty (resp_empty),
        .count (resp_cnt)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            pc       <= RESET_PC;
            order    <= '0;
            inflight <= '0;
            drop_cnt <= '0;
        end else begin
            inflight <= inflight + CW'(accept) - CW'(resp_any);
            if (redirect) begin
                pc       <= tgt_pc;
                order    <= tgt_order + 1'b1;
                drop_cnt <= inflight - CW'(resp_any);
            end else begin
                if (accept) begin
                    pc    <= pc + 32'd4;
                    order <= order + 1'b1;
                end
                if (resp_any && drop_cnt != '0) drop_cnt <= drop_cnt - 1'b1;
            end
        end
    end

    // Live requests sit in the meta FIFO; the rest are awaiting drop.
    always_ff @(posedge clk) begin
        if (rst) assert (CW'(meta_cnt + drop_cnt) == inflight);
    end

endmodule

// File: tb/tb_fetch_pipelined.sv
// Randomised bench for fetch_pipelined with an in-order memory and
// a queue-based reference model of the fetch behaviour.
module tb_fetch_pipelined;
    import rv32i_types::*;

    localparam int          MAXO   = 4;
    localparam logic [31:0] RST_PC = 32'h6000_0000;

    typedef struct {
        logic [31:0] pc;
        logic [63:0] order;
        bit          live;
        int          due;
    } mreq_t;

    logic         clk = 1'b0;
    logic         rst;
    logic [31:0]  imem_addr;
    logic [3:0]   imem_rmask;
    logic         imem_ready;
    logic [31:0]  imem_rdata;
    logic         imem_resp;
    logic         full_fq;
    logic         fetch_valid;
    fetch_queue_t fetch_data;
    logic         br_flush;
    logic [31:0]  br_addr;
    logic [63:0]  br_order;
    logic         jal_ready;
    logic [31:0]  jal_addr;
    logic [63:0]  jal_order;

    always #5 clk = ~clk;

    fetch_pipelined dut (
        .clk         (clk),
        .rst         (rst),
        .imem_addr   (imem_addr),
        .imem_rmask  (imem_rmask),
        .imem_ready  (imem_ready),
        .imem_rdata  (imem_rdata),
        .imem_resp   (imem_resp),
        .full_fq     (full_fq),
        .fetch_valid (fetch_valid),
        .fetch_data  (fetch_data),
        .br_flush    (br_flush),
        .br_addr     (br_addr),
        .br_order    (br_order),
        .jal_ready   (jal_ready),
        .jal_addr    (jal_addr),
        .jal_order   (jal_order)
    );

    mreq_t        mq[$];
    fetch_queue_t eq[$];
    fetch_queue_t got[$];
    logic [31:0]  acc[$];
    logic [31:0]  m_pc;
    logic [63:0]  m_order;
    logic [31:0]  s_addr;
    int           cyc;
    int           n_cmp;
    int           n_bad;
    int           resp_pct;
    int           lat_max;

    function automatic logic [31:0] mem_data(logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    task automatic check(string name, logic [159:0] act, logic [159:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    task automatic step();
        logic        redir;
        logic [31:0] tpc;
        logic [63:0] tord;
        logic        exp_issue;
        logic        exp_fv;
        mreq_t       h;
        @(negedge clk);
        imem_resp  = 1'b0;
        imem_rdata = 32'h0;
        if (rst && mq.size() > 0 && mq[0].due <= cyc
            && $urandom_range(99) < resp_pct) begin
            imem_resp  = 1'b1;
            imem_rdata = mem_data(mq[0].pc);
        end
        #1;
        redir     = br_flush | jal_ready;
        tpc       = br_flush ? br_addr : jal_addr;
        tord      = br_flush ? br_order : jal_order;
        exp_issue = rst && !redir && (mq.size() + eq.size() < MAXO);
        exp_fv    = rst && !redir && eq.size() > 0;
        s_addr    = imem_addr;
        check("rmask", 160'(imem_rmask), exp_issue ? 160'hf : 160'h0);
        if (exp_issue) check("imem_addr", 160'(imem_addr), 160'(m_pc));
        check("fetch_valid", 160'(fetch_valid), 160'(exp_fv));
        if (exp_fv) check("fetch_data", fetch_data, eq[0]);
        if (!rst) begin
            mq.delete();
            eq.delete();
            m_pc    = RST_PC;
            m_order = 64'd0;
        end else begin
            if (exp_fv && !full_fq) begin
                got.push_back(eq[0]);
                void'(eq.pop_front());
            end
            if (imem_resp) begin
                h = mq.pop_front();
                if (h.live && !redir)
                    eq.push_back('{inst: imem_rdata, pc: h.pc,
                                   pc_next: h.pc + 32'd4, order: h.order});
            end
            if (redir) begin
                foreach (mq[i]) mq[i].live = 1'b0;
                eq.delete();
                m_pc    = tpc;
                m_order = tord + 64'd1;
            end else if (exp_issue && imem_ready) begin
                acc.push_back(m_pc);
                mq.push_back('{pc: m_pc, order: m_order, live: 1'b1,
                               due: cyc + 1 + int'($urandom_range(lat_max))});
                m_pc    = m_pc + 32'd4;
                m_order = m_order + 64'd1;
            end
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic run(int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic do_reset();
        rst = 1'b0;
        run(2);
        rst = 1'b1;
        got.delete();
        acc.delete();
    endtask

    task automatic idle_inputs();
        imem_ready = 1'b1;
        full_fq    = 1'b0;
        br_flush   = 1'b0;
        jal_ready  = 1'b0;
        resp_pct   = 100;
        lat_max    = 0;
    endtask

    initial begin
        int n0;
        logic [31:0] a0;
        n_cmp = 0;
        n_bad = 0;
        cyc   = 0;
        m_pc  = RST_PC;
        m_order = 64'd0;
        rst = 1'b0;
        imem_resp = 1'b0;
        imem_rdata = 32'h0;
        br_addr = 32'h0;
        br_order = 64'h0;
        jal_addr = 32'h0;
        jal_order = 64'h0;
        idle_inputs();

        // Streaming after reset release
        do_reset();
        run(8);
        check("stream_accepts", 160'(acc.size()), 160'd8);
        check("stream_addr0", 160'(acc[0]), 160'h6000_0000);
        check("stream_addr1", 160'(acc[1]), 160'h6000_0004);
        check("stream_addr2", 160'(acc[2]), 160'h6000_0008);
        check("stream_ndeliv", 160'(got.size() >= 3), 160'd1);
        check("stream_ord0", 160'(got[0].order), 160'd0);
        check("stream_ord1", 160'(got[1].order), 160'd1);
        check("stream_ord2", 160'(got[2].order), 160'd2);
        check("stream_inst0", 160'(got[0].inst), 160'(mem_data(RST_PC)));

        // Back-pressure limits outstanding work
        do_reset();
        full_fq = 1'b1;
        run(10);
        check("fq_req_count", 160'(acc.size()), 160'd4);
        check("fq_rmask_idle", 160'(imem_rmask), 160'h0);
        full_fq = 1'b0;
        run(6);
        check("fq_ndeliv", 160'(got.size() >= 4), 160'd1);
        check("fq_ord0", 160'(got[0].order), 160'd0);
        check("fq_ord3", 160'(got[3].order), 160'd3);

        // Branch flush with three requests in flight
        do_reset();
        resp_pct = 0;
        run(3);
        check("br_inflight", 160'(acc.size()), 160'd3);
        br_flush = 1'b1;
        br_addr  = 32'h6000_0100;
        br_order = 64'd9;
        run(1);
        br_flush = 1'b0;
        resp_pct = 100;
        run(12);
        check("br_ndeliv", 160'(got.size() > 0), 160'd1);
        check("br_pc", 160'(got[0].pc), 160'h6000_0100);
        check("br_order", 160'(got[0].order), 160'd10);

        // Simultaneous branch and jump, response in the redirect cycle
        do_reset();
        resp_pct = 0;
        run(3);
        br_flush  = 1'b1;
        br_addr   = 32'h6000_0200;
        br_order  = 64'd20;
        jal_ready = 1'b1;
        jal_addr  = 32'h6000_0300;
        jal_order = 64'd30;
        resp_pct  = 100;
        run(1);
        br_flush  = 1'b0;
        jal_ready = 1'b0;
        run(12);
        check("both_pc", 160'(got[0].pc), 160'h6000_0200);
        check("both_order", 160'(got[0].order), 160'd21);

        // Reset mid-stream with two requests outstanding
        do_reset();
        resp_pct = 0;
        run(2);
        rst = 1'b0;
        run(1);
        check("rst_fv", 160'(fetch_valid), 160'd0);
        rst = 1'b1;
        resp_pct = 100;
        acc.delete();
        got.delete();
        run(8);
        check("rst_addr0", 160'(acc[0]), 160'h6000_0000);
        check("rst_pc0", 160'(got[0].pc), 160'h6000_0000);
        check("rst_ord0", 160'(got[0].order), 160'd0);

        // Memory stall holds the request
        imem_ready = 1'b0;
        n0 = acc.size();
        run(1);
        a0 = s_addr;
        for (int i = 0; i < 4; i++) begin
            step();
            check("stall_addr", 160'(s_addr), 160'(a0));
        end
        check("stall_accepts", 160'(acc.size()), 160'(n0));
        imem_ready = 1'b1;
        run(4);

        // PC and order wrap on redirect
        do_reset();
        jal_ready = 1'b1;
        jal_addr  = 32'hFFFF_FFFC;
        jal_order = 64'hFFFF_FFFF_FFFF_FFFF;
        run(1);
        jal_ready = 1'b0;
        run(8);
        check("wrap_pc0", 160'(got[0].pc), 160'hFFFF_FFFC);
        check("wrap_next0", 160'(got[0].pc_next), 160'h0);
        check("wrap_ord0", 160'(got[0].order), 160'd0);
        check("wrap_pc1", 160'(got[1].pc), 160'h0);

        // Random traffic
        resp_pct = 70;
        lat_max  = 3;
        for (int i = 0; i < 3000; i++) begin
            rst        = $urandom_range(199) != 0;
            imem_ready = $urandom_range(99) < 70;
            full_fq    = $urandom_range(99) < 30;
            br_flush   = $urandom_range(99) < 4;
            jal_ready  = $urandom_range(99) < 4;
            br_addr    = $urandom() & 32'hFFFF_FFFC;
            jal_addr   = $urandom() & 32'hFFFF_FFFC;
            br_order   = {$urandom(), $urandom()};
            jal_order  = {$urandom(), $urandom()};
            step();
        end
        idle_inputs();
        run(20);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/fetch_pipelined.md
FETCH_PIPELINED -- requirements
Module: fetch_pipelined

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h60000000, meaning the PC loaded on reset.
REQ-002 SHALL have parameter MAX_OUTSTANDING, default 4, meaning the in-flight plus buffered fetch limit; legal values are powers of two from 2 to 16.
REQ-003 SHALL have parameter ORDER_W, default 64, meaning the width of the order counter.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, synchronous and active-low.
REQ-006 SHALL have port imem_addr, output, 32 bits: the fetch request address.
REQ-007 SHALL have port imem_rmask, output, 4 bits: 4'b1111 marks a request this cycle; 4'b0000 means idle.
REQ-008 SHALL have port imem_ready, input, 1 bit: memory accepts a request this cycle.
REQ-009 SHALL have ports imem_rdata (input, 32 bits) and imem_resp (input, 1 bit): in-order response data and its valid strobe.
REQ-010 SHALL have port full_fq, input, 1 bit: the fetch queue cannot accept an entry.
REQ-011 SHALL have ports fetch_valid (output, 1 bit) and fetch_data (output, fetch_queue_t): a delivery to the fetch queue.
REQ-012 SHALL have ports br_flush (input, 1), br_addr (input, 32) and br_order (input, ORDER_W): mispredict redirect.
REQ-013 SHALL have ports jal_ready (input, 1), jal_addr (input, 32) and jal_order (input, ORDER_W): jump redirect.

Function
REQ-014 SHALL issue a request (rmask=1111, imem_addr=pc) when: not in reset; no redirect this cycle; (inflight + buffered) < MAX_OUTSTANDING.
REQ-015 SHALL treat a request as accepted only when issued and imem_ready=1; on acceptance: pc += 4, order += 1, and {pc, pc+4, order} is pushed to the meta FIFO.
REQ-016 SHALL hold imem_addr and rmask stable while issuing with imem_ready=0.
REQ-017 SHALL assume memory returns responses in request order; a response with drop_cnt=0 pops the meta FIFO and pushes {imem_rdata, meta} to the response FIFO in the same cycle.
REQ-018 SHALL assert fetch_valid whenever the response FIFO is non-empty; fetch_data is then its head; the entry pops when fetch_valid=1 and full_fq=0.
REQ-019 SHALL give zero bubble latency: a response arriving on an empty FIFO appears at the output on the next cycle.
REQ-020 SHALL prioritise br_flush over jal_ready when both are asserted.
REQ-021 SHALL, on a redirect, set pc to the target address and order to the redirect order + 1.
REQ-022 SHALL, on a redirect, flush the meta FIFO and the response FIFO and suppress fetch_valid in that cycle.
REQ-023 SHALL, on a redirect, set drop_cnt = inflight − (imem_resp ? 1 : 0), so stale responses are discarded.
REQ-024 SHALL decrement drop_cnt by one on each imem_resp while drop_cnt > 0 and discard that data.
REQ-025 SHALL issue no request in the redirect cycle; issue resumes at the target on the next cycle, even while drops are still pending.
REQ-026 SHALL count inflight in 0..MAX_OUTSTANDING, covering both live and dropped requests.
REQ-027 SHALL size counters at $clog2(MAX_OUTSTANDING)+1 bits and never let them overflow or underflow; pc and order wrap modulo 2^32 and 2^ORDER_W.

Reset
REQ-028 SHALL, while rst=0 at a clock edge, set pc=RESET_PC, order=0, inflight=0, drop_cnt=0 and empty both FIFOs.
REQ-029 SHALL drive fetch_valid=0 and imem_rmask=0 during reset.
REQ-030 SHALL discard any response that arrives from a request issued before a reset.

Structure
REQ-031 SHALL take fetch_queue_t {inst, pc, pc_next, order} and the fetch-meta struct typedef from rv32i_types.
REQ-032 SHALL implement both buffers as one sub-module, fetch_fifo, parametrised by width and depth and providing push, pop, flush, full, empty and count.

Verification
REQ-033 SHALL cover: reset release with imem_ready=1 and 1-cycle responses -> addresses 0x60000000, 0x60000004, ... issued every cycle; delivered orders 0, 1, 2 in sequence.
REQ-034 SHALL cover: MAX_OUTSTANDING=4 with full_fq held high -> exactly 4 requests, then rmask=0; releasing full_fq drains 4 entries in order.
REQ-035 SHALL cover: 3 requests in flight, then br_flush with br_addr=0x60000100 and br_order=9 -> 3 responses dropped; first delivery has pc=0x60000100 and order=10.
REQ-036 SHALL cover: br_flush and jal_ready in the same cycle -> br target wins; a response arriving that cycle is dropped and counted (drop_cnt = inflight − 1).
REQ-037 SHALL cover: rst driven low mid-stream with 2 requests in flight -> fetch_valid=0; pc=0x60000000 after release; no stale data delivered.
REQ-038 SHALL cover: imem_ready low for 5 cycles -> imem_addr held stable; no pc or order advance.
